// File: rtl/rv_pkg.sv
// ============================================================================
//  Module  : rv_pkg
//  Brief   : Shared opcodes, FSM state encoding and datapath select encodings
//            for the RV32I multi-cycle controller.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  // RV32I major opcodes handled by the controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Controller states; the numeric value is exported on state_o for debug
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  // True for every opcode the core implements; anything else traps
  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH,
      OP_JAL, OP_LUI, OP_OP: is_legal_op = 1'b1;
      default:               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_timeout.sv
// ============================================================================
//  Module  : mem_timeout
//  Brief   : Wait-cycle counter for a req/ready handshake. Flags expiry when
//            the request has waited TIMEOUT_CYC cycles without ready.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic ready_i,
  output logic expire_o
);

  // Last count value before the limit is reached; a further not-ready cycle expires
  localparam logic [15:0] c_last_cnt = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Count only cycles spent waiting; any idle or completed cycle restarts the count,
  // so every fresh request (FETCH or MEM entry) starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || ready_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Ready in the final waiting cycle suppresses expiry
  assign expire_o = req_i & ~ready_i & (cnt_q == c_last_cnt);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module  : multicycle_ctrl
//  Brief   : Multi-cycle control FSM for the RV32I core. Sequences fetch,
//            decode, execute, memory and write-back over a shared datapath
//            and traps on illegal opcodes or memory timeouts.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        br_cond,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state_o
);

  state_t state_q;
  state_t state_d;
  logic   illegal_q;

  logic [6:0] opcode;
  logic       rd_nz;
  logic       tmo_req;
  logic       tmo_ready;
  logic       tmo_expire;
  logic       instr_unused;

  assign opcode       = instr[6:0];
  assign rd_nz        = (instr[11:7] != 5'd0);
  assign instr_unused = ^instr[31:12];

  // Only one memory request is ever outstanding, so one counter serves both ports
  assign tmo_req   = (state_q == FETCH) || (state_q == MEM);
  assign tmo_ready = (state_q == FETCH) ? imem_ready : dmem_ready;

  mem_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_mem_timeout (
    .clk      (clk),
    .reset    (reset),
    .req_i    (tmo_req),
    .ready_i  (tmo_ready),
    .expire_o (tmo_expire)
  );

  // Next-state selection and strobe decode from the current state and IR opcode
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = illegal_q;
    state_o   = state_q;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = PC_PLUS4;
          state_d = DECODE;
        end else if (tmo_expire) begin
          state_d = TRAP;
        end
      end

      DECODE: begin
        state_d = is_legal_op(opcode) ? EXECUTE : TRAP;
      end

      EXECUTE: begin
        state_d = FETCH;
        case (opcode)
          OP_OP: begin
            alu_op    = ALU_FUNCT;
            alu_src_b = 1'b0;
            state_d   = WB;
          end
          OP_IMM: begin
            alu_op    = ALU_FUNCT;
            alu_src_b = 1'b1;
            state_d   = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_d   = MEM;
          end
          OP_BRANCH: begin
            alu_op = ALU_SUB;
            if (br_cond) begin
              pc_we  = 1'b1;
              pc_sel = PC_IMM;
            end
          end
          OP_JAL: begin
            reg_we = rd_nz;
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_sel = PC_IMM;
          end
          OP_LUI: begin
            reg_we = rd_nz;
            wb_sel = WB_IMM;
          end
          default: state_d = FETCH;
        endcase
      end

      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          state_d = (opcode == OP_STORE) ? FETCH : WB;
        end else if (tmo_expire) begin
          state_d = TRAP;
        end
      end

      WB: begin
        reg_we  = rd_nz;
        wb_sel  = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
        state_d = FETCH;
      end

      TRAP: begin
        state_d = TRAP;
      end

      default: state_d = FETCH;
    endcase

    // Reset silences every output immediately, aborting any pending request or write
    if (reset) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      reg_we    = 1'b0;
      wb_sel    = WB_ALU;
      illegal   = 1'b0;
      state_o   = 3'd0;
    end
  end

  // State register and sticky trap flag; TRAP is only left through reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_d == TRAP);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module  : tb_multicycle_ctrl
//  Brief   : Self-checking bench for multicycle_ctrl. Each instruction is
//            expanded into its expected per-cycle output schedule from the
//            instruction class and the ready delays, and compared per cycle.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam int TMO = 4;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_EXE   = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_TRAP  = 3'd5;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       illegal;
    logic [2:0] st;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        br_cond = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_b, reg_we, illegal;
  logic [1:0]  pc_sel, alu_op, wb_sel;
  logic [2:0]  state_o;
  logic [16:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .br_cond    (br_cond),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_b,
                alu_op, reg_we, wb_sel, illegal, state_o};

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h (instr %08h)", tag, got, exp, instr);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected outputs with every strobe idle in the given state
  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e         = '0;
    e.st      = st;
    e.illegal = (st == S_TRAP);
    return e;
  endfunction

  function automatic logic legal_op(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b0110111, 7'b0110011};
  endfunction

  // One clock: drive inputs after the falling edge, compare shortly afterwards
  task automatic step(input logic [31:0] w, input logic ir, input logic dr,
                      input logic bc, input logic rs, input obs_t e, input string tag);
    @(negedge clk);
    instr      = w;
    imem_ready = ir;
    dmem_ready = dr;
    br_cond    = bc;
    reset      = rs;
    #1;
    chk(tag, obs, e);
  endtask

  // A few cycles stuck in TRAP with arbitrary inputs, then a reset cycle
  task automatic trap_then_reset(input logic [31:0] w);
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) step(w, rb(), rb(), rb(), 1'b0, base(S_TRAP), "TRAP");
    step(w, rb(), rb(), rb(), 1'b1, '0, "RESET");
  endtask

  // Full life of one instruction: idly/ddly are the not-ready cycles before ready
  task automatic run_instr(input logic [31:0] w, input logic brc, input int idly, input int ddly);
    obs_t       e;
    logic [6:0] op;
    logic       rdnz, is_ld, is_st;
    op    = w[6:0];
    rdnz  = (w[11:7] != 5'd0);
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);

    e = base(S_FETCH);
    e.imem_req = 1'b1;
    for (int i = 0; i < idly && i < TMO; i++) step(w, 1'b0, rb(), rb(), 1'b0, e, "FETCH_WAIT");
    if (idly >= TMO) begin
      trap_then_reset(w);
      return;
    end
    e.ir_we = 1'b1;
    e.pc_we = 1'b1;
    step(w, 1'b1, rb(), rb(), 1'b0, e, "FETCH_RDY");

    step(w, rb(), rb(), rb(), 1'b0, base(S_DEC), "DECODE");
    if (!legal_op(op)) begin
      trap_then_reset(w);
      return;
    end

    e = base(S_EXE);
    case (op)
      7'b0110011: begin e.alu_op = 2'd2; e.alu_src_b = 1'b0; end
      7'b0010011: begin e.alu_op = 2'd2; e.alu_src_b = 1'b1; end
      7'b0000011, 7'b0100011: begin e.alu_op = 2'd0; e.alu_src_b = 1'b1; end
      7'b1100011: begin e.alu_op = 2'd1; e.pc_we = brc; e.pc_sel = brc ? 2'd1 : 2'd0; end
      7'b1101111: begin e.reg_we = rdnz; e.wb_sel = 2'd2; e.pc_we = 1'b1; e.pc_sel = 2'd1; end
      default:    begin e.reg_we = rdnz; e.wb_sel = 2'd3; end
    endcase
    step(w, rb(), rb(), (op == 7'b1100011) ? brc : rb(), 1'b0, e, "EXECUTE");

    if (is_ld || is_st) begin
      e = base(S_MEM);
      e.dmem_req = 1'b1;
      e.dmem_we  = is_st;
      for (int i = 0; i < ddly && i < TMO; i++) step(w, rb(), 1'b0, rb(), 1'b0, e, "MEM_WAIT");
      if (ddly >= TMO) begin
        trap_then_reset(w);
        return;
      end
      step(w, rb(), 1'b1, rb(), 1'b0, e, "MEM_RDY");
    end

    if (is_ld || op == 7'b0110011 || op == 7'b0010011) begin
      e = base(S_WB);
      e.reg_we = rdnz;
      e.wb_sel = is_ld ? 2'd1 : 2'd0;
      step(w, rb(), rb(), rb(), 1'b0, e, "WB");
    end
  endtask

  // Load that is reset while waiting on data memory: everything drops at once
  task automatic abort_load(input logic [31:0] w);
    obs_t e;
    e = base(S_FETCH); e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    step(w, 1'b1, 1'b0, 1'b0, 1'b0, e, "AB_FETCH");
    step(w, 1'b0, 1'b0, 1'b0, 1'b0, base(S_DEC), "AB_DECODE");
    e = base(S_EXE); e.alu_src_b = 1'b1;
    step(w, 1'b0, 1'b0, 1'b0, 1'b0, e, "AB_EXECUTE");
    e = base(S_MEM); e.dmem_req = 1'b1;
    step(w, 1'b0, 1'b0, 1'b0, 1'b0, e, "AB_MEM_WAIT");
    step(w, 1'b0, 1'b1, 1'b0, 1'b1, '0, "AB_RESET");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [7];
    int          r;
    ops = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b0110011};
    w = $urandom();
    r = $urandom_range(0, 15);
    if (r < 14) begin
      w[6:0] = ops[r % 7];
    end else begin
      while (legal_op(w[6:0])) w[6:0] = 7'($urandom());
    end
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  function automatic int rand_dly();
    if ($urandom_range(0, 9) == 0) return $urandom_range(TMO, TMO + 2);
    return $urandom_range(0, TMO - 1);
  endfunction

  initial begin
    // Outputs stay silent while reset is held
    step(32'h0, 1'b1, 1'b1, 1'b1, 1'b1, '0, "RESET_HOLD");
    step(32'h0, 1'b1, 1'b1, 1'b1, 1'b1, '0, "RESET_HOLD");

    run_instr(32'h00500093, 1'b0, 0, 0);  // addi x1,x0,5
    run_instr(32'h0000A103, 1'b0, 0, 3);  // lw x2,0(x1), data ready after 3 cycles
    run_instr(32'h0020A223, 1'b0, 0, 0);  // sw x2,4(x1)
    run_instr(32'h00000463, 1'b1, 0, 0);  // beq taken
    run_instr(32'h00000463, 1'b0, 0, 0);  // beq not taken
    run_instr(32'h00000037, 1'b0, 0, 0);  // lui x0: write suppressed
    run_instr(32'h0080006F, 1'b0, 0, 0);  // jal x0
    run_instr(32'h00500093, 1'b0, TMO - 1, 0);  // ready in the last allowed cycle
    run_instr(32'hFFFFFFFF, 1'b0, 0, 0);  // illegal opcode -> TRAP
    run_instr(32'h00500093, 1'b0, TMO, 0);      // instruction fetch timeout
    run_instr(32'h0000A103, 1'b0, 1, TMO);      // data timeout
    abort_load(32'h0000A103);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 24) == 0) abort_load(32'h0000A103);
      else run_instr(rand_instr(), rb(), rand_dly(), rand_dly());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
